dmem_dp_ram: RTL and testbench

Parametrised true dual-port data memory. It replaces the fixed 17-bit-address / 40-bit-data dual-port dmem simulator model, and both datapath ports share one clock. It adds:
- configurable read latency
- read-during-write mode
- deterministic write-collision arbitration
- out-of-range detection
- a post-reset clearing sweep, so contents are defined (zero) before first use

It sits between the core's load/store units (port A) and the DMA/debug path (port B).

---
 rtl/dmem_dp_ram.sv | 167 ++++++++++++++++
 tb/tb_dmem_dp_ram.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dp_ram.sv
// True dual-port data memory: A = load/store, B = DMA/debug, shared clock, zero-fill sweep after reset.
// Optional `define DMEM_COLLISION_DET_EN adds the coll_cnt / coll_pulse collision monitor.
module dmem_dp_ram #(
  parameter int DATA_W  = 40,
  parameter int ADDR_W  = 17,
  parameter int DEPTH   = 1024,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              wea,
  input  logic              ena,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  input  logic              web,
  input  logic              enb,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic [1:0]        oob,
  output logic              init_done
`ifdef DMEM_COLLISION_DET_EN
  ,
  output logic [15:0]       coll_cnt,
  output logic [0:0]        coll_pulse
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic               run;
  logic               sweep_last;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               ina, inb;
  logic [IDX_W-1:0]   idxa, idxb;
  logic               req_a, req_b;
  logic               wr_a, wr_b;
  logic [DATA_W-1:0]  rda, rdb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep_last) state_nxt = RUN;
  end

  always_comb begin
    run       = (state == RUN);
    init_done = run;
  end

  assign sweep_last = (cnt == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (!run) cnt <= cnt + IDX_W'(1);
  end

  assign ina   = (32'(addra) < DEPTH);
  assign inb   = (32'(addrb) < DEPTH);
  assign idxa  = addra[IDX_W-1:0];
  assign idxb  = addrb[IDX_W-1:0];
  assign req_a = run & ena;
  assign req_b = run & enb;
  assign wr_a  = req_a & wea & ina;
  // Port A owns the word when both ports write the same address.
  assign wr_b  = req_b & web & inb & ~(wr_a && (idxa == idxb));

  // Out-of-range accesses read as zero; write-first only ever forwards the port's own data.
  assign rda = !ina ? '0 : ((WR_MODE != 0) && wea) ? dina : mem[idxa];
  assign rdb = !inb ? '0 : ((WR_MODE != 0) && web) ? dinb : mem[idxb];

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_a) mem[idxa] <= dina;
      if (wr_b) mem[idxb] <= dinb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob <= 2'b00;
    else        oob <= oob | {req_b & ~inb, req_a & ~ina};
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] da_p0, db_p0;
      logic              vld_a_p0, vld_b_p0;

      // Stage p0: capture read data at the request edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_a_p0 <= 1'b0;
          vld_b_p0 <= 1'b0;
          da_p0    <= '0;
          db_p0    <= '0;
        end else begin
          vld_a_p0 <= req_a;
          vld_b_p0 <= req_b;
          if (req_a) da_p0 <= rda;
          if (req_b) db_p0 <= rdb;
        end
      end

      // Stage p1: output registers, hold when not valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valida <= 1'b0;
          validb <= 1'b0;
          douta  <= '0;
          doutb  <= '0;
        end else begin
          valida <= vld_a_p0;
          validb <= vld_b_p0;
          if (vld_a_p0) douta <= da_p0;
          if (vld_b_p0) doutb <= db_p0;
        end
      end
    end else begin : g_lat1
      // Stage p0: output registers loaded directly at the request edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valida <= 1'b0;
          validb <= 1'b0;
          douta  <= '0;
          doutb  <= '0;
        end else begin
          valida <= req_a;
          validb <= req_b;
          if (req_a) douta <= rda;
          if (req_b) doutb <= rdb;
        end
      end
    end
  endgenerate

`ifdef DMEM_COLLISION_DET_EN
  logic coll_ev;

  assign coll_ev = req_a & req_b & (addra == addrb) & (wea | web);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt   <= '0;
      coll_pulse <= 1'b0;
    end else begin
      coll_pulse <= coll_ev;
      if (coll_ev && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_dp_ram.sv
// Directed bench for dmem_dp_ram: u0 = RD_LAT 1 / read-first, u1 = RD_LAT 2 / write-first, shared stimulus.
module tb_dmem_dp_ram;
  localparam int DATA_W = 40;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [ADDR_W-1:0] addra, addrb;
  logic [DATA_W-1:0] dina, dinb;
  logic wea, ena, web, enb;

  logic [DATA_W-1:0] douta0, doutb0, douta1, doutb1;
  logic valida0, validb0, valida1, validb1;
  logic [1:0] oob0, oob1;
  logic init_done0, init_done1;
`ifdef DMEM_COLLISION_DET_EN
  logic [15:0] coll_cnt0, coll_cnt1;
  logic [0:0]  coll_pulse0, coll_pulse1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1), .WR_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena), .douta(douta0), .valida(valida0),
    .addrb(addrb), .dinb(dinb), .web(web), .enb(enb), .doutb(doutb0), .validb(validb0),
    .oob(oob0), .init_done(init_done0)
`ifdef DMEM_COLLISION_DET_EN
    , .coll_cnt(coll_cnt0), .coll_pulse(coll_pulse0)
`endif
  );

  dmem_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2), .WR_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena), .douta(douta1), .valida(valida1),
    .addrb(addrb), .dinb(dinb), .web(web), .enb(enb), .doutb(doutb1), .validb(validb1),
    .oob(oob1), .init_done(init_done1)
`ifdef DMEM_COLLISION_DET_EN
    , .coll_cnt(coll_cnt1), .coll_pulse(coll_pulse1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
    enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated request on both ports; expected data per DUT (u0 after 1 edge, u1 after 2).
  task automatic op(input string tag,
                    input logic ae, input logic awe, input logic [ADDR_W-1:0] aad, input logic [DATA_W-1:0] adi,
                    input logic be, input logic bwe, input logic [ADDR_W-1:0] bad, input logic [DATA_W-1:0] bdi,
                    input logic [DATA_W-1:0] ea0, input logic [DATA_W-1:0] eb0,
                    input logic [DATA_W-1:0] ea1, input logic [DATA_W-1:0] eb1);
    ena = ae; wea = awe; addra = aad; dina = adi;
    enb = be; web = bwe; addrb = bad; dinb = bdi;
    tick();
    idle();
    chk({tag, ".va0"}, valida0, ae);
    chk({tag, ".vb0"}, validb0, be);
    if (ae) chk({tag, ".da0"}, douta0, ea0);
    if (be) chk({tag, ".db0"}, doutb0, eb0);
    chk({tag, ".va1_early"}, valida1, 1'b0);
    tick();
    chk({tag, ".va0_off"}, valida0, 1'b0);
    chk({tag, ".vb0_off"}, validb0, 1'b0);
    chk({tag, ".va1"}, valida1, ae);
    chk({tag, ".vb1"}, validb1, be);
    if (ae) chk({tag, ".da1"}, douta1, ea1);
    if (be) chk({tag, ".db1"}, doutb1, eb1);
    tick();
    chk({tag, ".va1_off"}, valida1, 1'b0);
    chk({tag, ".vb1_off"}, validb1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst.init_done0", init_done0, 1'b0);
    chk("rst.init_done1", init_done1, 1'b0);
    chk("rst.valida0", valida0, 1'b0);
    chk("rst.validb1", validb1, 1'b0);
    chk("rst.douta0", douta0, '0);
    chk("rst.doutb1", doutb1, '0);
    chk("rst.oob0", oob0, 2'b00);
    chk("rst.oob1", oob1, 2'b00);
`ifdef DMEM_COLLISION_DET_EN
    chk("rst.coll_cnt0", coll_cnt0, 16'd0);
    chk("rst.coll_pulse1", coll_pulse1, 1'b0);
`endif

    // Sweep: requests during INIT must be ignored, init_done after exactly DEPTH edges.
    rst_n = 1'b1;
    ena = 1'b1; wea = 1'b1; addra = 5; dina = 40'h55;
    enb = 1'b1; web = 1'b1; addrb = 6; dinb = 40'h66;
    for (int i = 0; i < DEPTH; i++) begin
      chk("init.busy0", init_done0, 1'b0);
      chk("init.busy1", init_done1, 1'b0);
      tick();
      chk("init.va0", valida0, 1'b0);
      chk("init.vb0", validb0, 1'b0);
      chk("init.va1", valida1, 1'b0);
      chk("init.vb1", validb1, 1'b0);
    end
    chk("init.done0", init_done0, 1'b1);
    chk("init.done1", init_done1, 1'b1);
    idle();

    op("rd_init", 1, 0, 5, 0,    1, 0, 6, 0,    0, 0, 0, 0);
    op("wr01",    1, 1, 0, 1,    1, 1, 1, 2,    0, 0, 1, 2);
    op("rd10",    1, 0, 1, 0,    1, 0, 0, 0,    2, 1, 2, 1);

    // Write then read the same word on consecutive cycles.
    ena = 1'b1; wea = 1'b1; addra = 2; dina = 40'h22;
    tick();
    wea = 1'b0;
    chk("b2b.va0_wr", valida0, 1'b1);
    chk("b2b.da0_wr", douta0, 40'h0);
    tick();
    idle();
    chk("b2b.va0_rd", valida0, 1'b1);
    chk("b2b.da0_rd", douta0, 40'h22);
    chk("b2b.va1_wr", valida1, 1'b1);
    chk("b2b.da1_wr", douta1, 40'h22);
    tick();
    chk("b2b.va0_off", valida0, 1'b0);
    chk("b2b.va1_rd", valida1, 1'b1);
    chk("b2b.da1_rd", douta1, 40'h22);
    tick();
    chk("b2b.va1_off", valida1, 1'b0);

    op("wcol3",    1, 1, 3, 3,    1, 1, 3, 20,   0, 0, 3, 20);
    op("rd3",      1, 0, 3, 0,    1, 0, 3, 0,    3, 3, 3, 3);
    op("wr7",      1, 1, 7, 7,    0, 0, 0, 0,    0, 0, 7, 0);
    op("aw9_br7",  1, 1, 7, 9,    1, 0, 7, 0,    7, 7, 9, 7);
    op("ar7_bw11", 1, 0, 7, 0,    1, 1, 7, 11,   9, 9, 9, 11);
    op("rd7",      1, 0, 7, 0,    1, 0, 7, 0,    11, 11, 11, 11);

    op("oob_ra",   1, 0, 17'h20, 0,   0, 0, 0, 0,   0, 0, 0, 0);
    chk("oob_ra.flag0", oob0, 2'b01);
    chk("oob_ra.flag1", oob1, 2'b01);
    op("oob_wb",   0, 0, 0, 0,    1, 1, 17'h21, 40'h77,   0, 0, 0, 0);
    chk("oob_wb.flag0", oob0, 2'b11);
    chk("oob_wb.flag1", oob1, 2'b11);
    op("alias",    1, 0, 0, 0,    1, 0, 1, 0,    1, 2, 1, 2);
    chk("oob_sticky0", oob0, 2'b11);

    op("ena0",     0, 1, 4, 40'hAB,  0, 1, 4, 40'hCD,  0, 0, 0, 0);
    op("rd4",      1, 0, 4, 0,    1, 0, 4, 0,    0, 0, 0, 0);

`ifdef DMEM_COLLISION_DET_EN
    chk("coll.cnt0_3", coll_cnt0, 16'd3);
    chk("coll.cnt1_3", coll_cnt1, 16'd3);
    ena = 1'b1; wea = 1'b0; addra = 9;
    enb = 1'b1; web = 1'b1; addrb = 9; dinb = 40'h5;
    tick();
    idle();
    chk("coll.pulse0_hi", coll_pulse0, 1'b1);
    chk("coll.cnt0_4", coll_cnt0, 16'd4);
    tick();
    chk("coll.pulse0_lo", coll_pulse0, 1'b0);
    chk("coll.cnt1_4", coll_cnt1, 16'd4);
    tick();
`endif

    // Reset during RUN, then again mid-sweep at cycle 5.
    rst_n = 1'b0;
    #1;
    chk("rrst.oob0", oob0, 2'b00);
    chk("rrst.init_done0", init_done0, 1'b0);
    chk("rrst.douta0", douta0, '0);
`ifdef DMEM_COLLISION_DET_EN
    chk("rrst.coll_cnt0", coll_cnt0, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("mid.init_done0", init_done0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("resweep.busy0", init_done0, 1'b0);
      chk("resweep.busy1", init_done1, 1'b0);
      tick();
    end
    chk("resweep.done0", init_done0, 1'b1);
    chk("resweep.done1", init_done1, 1'b1);
    op("rd_clr",   1, 0, 3, 0,    1, 0, 7, 0,    0, 0, 0, 0);
    chk("resweep.oob0", oob0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
